// File: rtl/rob_pkg.sv
// Shared kind encodings, stop reasons and default sizing for the multi-port reorder buffer.
package rob_pkg;
   localparam int ROB_DEPTH    = 16;
   localparam int ROB_IDX_W    = 4;
   localparam int ROB_NUM_CDB  = 3;
   localparam int ROB_COMMIT_W = 2;
   localparam int ROB_XLEN     = 32;

   typedef enum logic [1:0] {
      ROB_K_REG    = 2'd0,
      ROB_K_STORE  = 2'd1,
      ROB_K_BRANCH = 2'd2,
      ROB_K_JALR   = 2'd3
   } rob_kind_e;

   // Why a commit group ended this cycle
   typedef enum logic [1:0] {
      ROB_STOP_WIDTH = 2'd0,
      ROB_STOP_WAIT  = 2'd1,
      ROB_STOP_CTRL  = 2'd2
   } rob_stop_e;

   function automatic logic rob_is_ctrl(input logic [1:0] kind);
      return (kind == ROB_K_BRANCH) || (kind == ROB_K_JALR);
   endfunction
endpackage

// File: rtl/rob_multiport_if.sv
// Bundle of dispatch, lookup, CDB, commit and branch-retire signals around the ROB.
interface rob_multiport_if #(
   parameter int IDX_W    = rob_pkg::ROB_IDX_W,
   parameter int NUM_CDB  = rob_pkg::ROB_NUM_CDB,
   parameter int COMMIT_W = rob_pkg::ROB_COMMIT_W,
   parameter int XLEN     = rob_pkg::ROB_XLEN
);
   logic                      disp_valid;
   logic                      disp_ready;
   logic [1:0]                disp_kind;
   logic [4:0]                disp_rd;
   logic [XLEN-1:0]           disp_pc;
   logic                      disp_pred_tk;
   logic [IDX_W-1:0]          disp_tag;

   logic [2*IDX_W-1:0]        rd_tag;
   logic [2*XLEN-1:0]         rd_data;
   logic [1:0]                rd_ready;

   logic [NUM_CDB-1:0]        cdb_valid;
   logic [NUM_CDB*IDX_W-1:0]  cdb_tag;
   logic [NUM_CDB*XLEN-1:0]   cdb_data;
   logic [NUM_CDB-1:0]        cdb_taken;
   logic [NUM_CDB*XLEN-1:0]   cdb_target;

   logic [COMMIT_W-1:0]       cm_we;
   logic [COMMIT_W*5-1:0]     cm_rd;
   logic [COMMIT_W*XLEN-1:0]  cm_data;
   logic [COMMIT_W*IDX_W-1:0] cm_tag;

   logic                      st_commit;
   logic [IDX_W-1:0]          st_tag;
   logic                      br_valid;
   logic [XLEN-1:0]           br_pc;
   logic [XLEN-1:0]           br_target;
   logic                      br_taken;
   logic                      br_mispredict;
   logic [IDX_W:0]            count;

   modport master (
      output disp_valid, disp_kind, disp_rd, disp_pc, disp_pred_tk, rd_tag,
             cdb_valid, cdb_tag, cdb_data, cdb_taken, cdb_target,
      input  disp_ready, disp_tag, rd_data, rd_ready, cm_we, cm_rd, cm_data, cm_tag,
             st_commit, st_tag, br_valid, br_pc, br_target, br_taken, br_mispredict, count
   );

   modport slave (
      input  disp_valid, disp_kind, disp_rd, disp_pc, disp_pred_tk, rd_tag,
             cdb_valid, cdb_tag, cdb_data, cdb_taken, cdb_target,
      output disp_ready, disp_tag, rd_data, rd_ready, cm_we, cm_rd, cm_data, cm_tag,
             st_commit, st_tag, br_valid, br_pc, br_target, br_taken, br_mispredict, count
   );
endinterface

// File: rtl/rob_commit_select.sv
// In-order retire selector over the head window: REG entries retire as a prefix,
// STORE/BRANCH/JALR retire alone from slot 0 and close the group.
module rob_commit_select
   import rob_pkg::*;
#(
   parameter int COMMIT_W = ROB_COMMIT_W
) (
   input  logic [COMMIT_W-1:0]      valid,
   input  logic [COMMIT_W-1:0]      ready,
   input  logic [COMMIT_W-1:0][1:0] kind,
   output logic [COMMIT_W-1:0]      retire,
   output rob_stop_e                stop
);
   logic go_s;

   // Prefix walk: once a slot fails or a control entry is seen, later slots hold
   always_comb begin
      retire = '0;
      stop   = ROB_STOP_WIDTH;
      go_s   = 1'b1;
      for (int k = 0; k < COMMIT_W; k++) begin
         if (!go_s) begin
            retire[k] = 1'b0;
         end else if (!(valid[k] && ready[k])) begin
            retire[k] = 1'b0;
            go_s      = 1'b0;
            stop      = ROB_STOP_WAIT;
         end else if (kind[k] != ROB_K_REG) begin
            retire[k] = (k == 0) ? 1'b1 : 1'b0;
            go_s      = 1'b0;
            stop      = ROB_STOP_CTRL;
         end else begin
            retire[k] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/rob_multiport.sv
// Circular reorder buffer with multi-port CDB write-back, operand lookup with bypass,
// multi-slot in-order commit and self-flush on a retiring mispredicted branch.
module rob_multiport
   import rob_pkg::*;
#(
   parameter int DEPTH    = ROB_DEPTH,
   parameter int IDX_W    = $clog2(DEPTH),
   parameter int NUM_CDB  = ROB_NUM_CDB,
   parameter int COMMIT_W = ROB_COMMIT_W,
   parameter int XLEN     = ROB_XLEN
) (
   input  logic           clk,
   input  logic           rst,
   rob_multiport_if.slave bus
);
   localparam int PTR_W = IDX_W + 1;

   logic [DEPTH-1:0]               valid_r;
   logic [DEPTH-1:0]               ready_r;
   logic [DEPTH-1:0]               pred_r;
   logic [DEPTH-1:0]               taken_r;
   logic [1:0]                     kind_r   [DEPTH];
   logic [4:0]                     rd_r     [DEPTH];
   logic [XLEN-1:0]                pc_r     [DEPTH];
   logic [XLEN-1:0]                data_r   [DEPTH];
   logic [XLEN-1:0]                target_r [DEPTH];
   logic [PTR_W-1:0]               head_r;
   logic [PTR_W-1:0]               tail_r;
   logic [PTR_W-1:0]               count_r;

   logic [COMMIT_W-1:0][IDX_W-1:0] win_idx_s;
   logic [COMMIT_W-1:0]            win_valid_s;
   logic [COMMIT_W-1:0]            win_ready_s;
   logic [COMMIT_W-1:0][1:0]       win_kind_s;
   logic [COMMIT_W-1:0]            retire_s;
   rob_stop_e                      stop_s;
   logic [PTR_W-1:0]               num_ret_s;
   logic [IDX_W-1:0]               idx0_s;
   logic                           full_s;
   logic                           acc_s;
   logic                           ctrl_ret_s;
   logic                           flush_s;
   logic [2*XLEN-1:0]              rd_data_s;
   logic [1:0]                     rd_ready_s;

   logic [COMMIT_W-1:0]            cm_we_r;
   logic [COMMIT_W*5-1:0]          cm_rd_r;
   logic [COMMIT_W*XLEN-1:0]       cm_data_r;
   logic [COMMIT_W*IDX_W-1:0]      cm_tag_r;
   logic                           st_commit_r;
   logic [IDX_W-1:0]               st_tag_r;
   logic                           br_valid_r;
   logic [XLEN-1:0]                br_pc_r;
   logic [XLEN-1:0]                br_target_r;
   logic                           br_taken_r;
   logic                           br_mispredict_r;

   // Same index with differing wrap bit means every slot is occupied
   assign full_s     = (head_r[IDX_W-1:0] == tail_r[IDX_W-1:0]) && (head_r[IDX_W] != tail_r[IDX_W]);
   assign acc_s      = bus.disp_valid && !full_s;
   assign idx0_s     = win_idx_s[0];
   assign ctrl_ret_s = retire_s[0] && (stop_s == ROB_STOP_CTRL) && rob_is_ctrl(win_kind_s[0]);
   assign flush_s    = ctrl_ret_s && (pred_r[idx0_s] != taken_r[idx0_s]);

   // Gather the entries at head..head+COMMIT_W-1 for the retire selector
   always_comb begin
      win_idx_s   = '0;
      win_valid_s = '0;
      win_ready_s = '0;
      win_kind_s  = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         win_idx_s[k]   = head_r[IDX_W-1:0] + IDX_W'(k);
         win_valid_s[k] = valid_r[win_idx_s[k]];
         win_ready_s[k] = ready_r[win_idx_s[k]];
         win_kind_s[k]  = kind_r[win_idx_s[k]];
      end
   end

   rob_commit_select #(
      .COMMIT_W (COMMIT_W)
   ) u_commit_select (
      .valid  (win_valid_s),
      .ready  (win_ready_s),
      .kind   (win_kind_s),
      .retire (retire_s),
      .stop   (stop_s)
   );

   // Number of entries leaving the head this cycle
   always_comb begin
      num_ret_s = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         num_ret_s = num_ret_s + PTR_W'(retire_s[k]);
      end
   end

   // Operand lookup; a matching CDB result this cycle overrides stored state, highest port last
   always_comb begin
      rd_data_s  = '0;
      rd_ready_s = '0;
      for (int r = 0; r < 2; r++) begin
         if (valid_r[bus.rd_tag[r*IDX_W +: IDX_W]]) begin
            rd_ready_s[r]            = ready_r[bus.rd_tag[r*IDX_W +: IDX_W]];
            rd_data_s[r*XLEN +: XLEN] = data_r[bus.rd_tag[r*IDX_W +: IDX_W]];
         end else begin
            rd_ready_s[r]            = 1'b0;
            rd_data_s[r*XLEN +: XLEN] = '0;
         end
         for (int p = 0; p < NUM_CDB; p++) begin
            rd_ready_s[r] = (bus.cdb_valid[p] && (bus.cdb_tag[p*IDX_W +: IDX_W] == bus.rd_tag[r*IDX_W +: IDX_W]))
                            ? 1'b1 : rd_ready_s[r];
            rd_data_s[r*XLEN +: XLEN] = (bus.cdb_valid[p] && (bus.cdb_tag[p*IDX_W +: IDX_W] == bus.rd_tag[r*IDX_W +: IDX_W]))
                            ? bus.cdb_data[p*XLEN +: XLEN] : rd_data_s[r*XLEN +: XLEN];
         end
      end
   end

   // Entry storage, pointers and occupancy; a flush drops that cycle's dispatch and CDB writes
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         valid_r <= '0;
         ready_r <= '0;
         pred_r  <= '0;
         taken_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            kind_r[i]   <= 2'd0;
            rd_r[i]     <= 5'd0;
            pc_r[i]     <= '0;
            data_r[i]   <= '0;
            target_r[i] <= '0;
         end
      end else if (flush_s) begin
         head_r  <= head_r + num_ret_s;
         tail_r  <= head_r + num_ret_s;
         count_r <= '0;
         valid_r <= '0;
         ready_r <= '0;
      end else begin
         for (int p = 0; p < NUM_CDB; p++) begin
            if (bus.cdb_valid[p] && valid_r[bus.cdb_tag[p*IDX_W +: IDX_W]]) begin
               ready_r[bus.cdb_tag[p*IDX_W +: IDX_W]]  <= 1'b1;
               data_r[bus.cdb_tag[p*IDX_W +: IDX_W]]   <= bus.cdb_data[p*XLEN +: XLEN];
               taken_r[bus.cdb_tag[p*IDX_W +: IDX_W]]  <= bus.cdb_taken[p];
               target_r[bus.cdb_tag[p*IDX_W +: IDX_W]] <= bus.cdb_target[p*XLEN +: XLEN];
            end
         end
         for (int k = 0; k < COMMIT_W; k++) begin
            if (retire_s[k]) begin
               valid_r[win_idx_s[k]] <= 1'b0;
               ready_r[win_idx_s[k]] <= 1'b0;
            end
         end
         if (acc_s) begin
            valid_r[tail_r[IDX_W-1:0]]  <= 1'b1;
            ready_r[tail_r[IDX_W-1:0]]  <= 1'b0;
            kind_r[tail_r[IDX_W-1:0]]   <= bus.disp_kind;
            rd_r[tail_r[IDX_W-1:0]]     <= bus.disp_rd;
            pc_r[tail_r[IDX_W-1:0]]     <= bus.disp_pc;
            pred_r[tail_r[IDX_W-1:0]]   <= bus.disp_pred_tk;
            data_r[tail_r[IDX_W-1:0]]   <= '0;
            taken_r[tail_r[IDX_W-1:0]]  <= 1'b0;
            target_r[tail_r[IDX_W-1:0]] <= '0;
         end
         head_r  <= head_r + num_ret_s;
         tail_r  <= tail_r + PTR_W'(acc_s);
         count_r <= count_r + PTR_W'(acc_s) - num_ret_s;
      end
   end

   // Registered retire outputs toward regfile, LSQ and branch predictor
   always_ff @(posedge clk) begin
      if (!rst) begin
         cm_we_r         <= '0;
         cm_rd_r         <= '0;
         cm_data_r       <= '0;
         cm_tag_r        <= '0;
         st_commit_r     <= 1'b0;
         st_tag_r        <= '0;
         br_valid_r      <= 1'b0;
         br_pc_r         <= '0;
         br_target_r     <= '0;
         br_taken_r      <= 1'b0;
         br_mispredict_r <= 1'b0;
      end else begin
         for (int k = 0; k < COMMIT_W; k++) begin
            cm_we_r[k] <= retire_s[k]
                          && ((win_kind_s[k] == ROB_K_REG) || (win_kind_s[k] == ROB_K_JALR))
                          && (rd_r[win_idx_s[k]] != 5'd0);
            cm_rd_r[k*5 +: 5]          <= retire_s[k] ? rd_r[win_idx_s[k]] : 5'd0;
            cm_data_r[k*XLEN +: XLEN]  <= retire_s[k] ? data_r[win_idx_s[k]] : '0;
            cm_tag_r[k*IDX_W +: IDX_W] <= retire_s[k] ? win_idx_s[k] : '0;
         end
         st_commit_r     <= retire_s[0] && (win_kind_s[0] == ROB_K_STORE);
         st_tag_r        <= (retire_s[0] && (win_kind_s[0] == ROB_K_STORE)) ? idx0_s : '0;
         br_valid_r      <= ctrl_ret_s;
         br_pc_r         <= ctrl_ret_s ? pc_r[idx0_s] : '0;
         br_target_r     <= ctrl_ret_s ? target_r[idx0_s] : '0;
         br_taken_r      <= ctrl_ret_s && taken_r[idx0_s];
         br_mispredict_r <= flush_s;
      end
   end

   assign bus.disp_ready    = !full_s;
   assign bus.disp_tag      = tail_r[IDX_W-1:0];
   assign bus.rd_data       = rd_data_s;
   assign bus.rd_ready      = rd_ready_s;
   assign bus.cm_we         = cm_we_r;
   assign bus.cm_rd         = cm_rd_r;
   assign bus.cm_data       = cm_data_r;
   assign bus.cm_tag        = cm_tag_r;
   assign bus.st_commit     = st_commit_r;
   assign bus.st_tag        = st_tag_r;
   assign bus.br_valid      = br_valid_r;
   assign bus.br_pc         = br_pc_r;
   assign bus.br_target     = br_target_r;
   assign bus.br_taken      = br_taken_r;
   assign bus.br_mispredict = br_mispredict_r;
   assign bus.count         = count_r;
endmodule

// File: tb/tb_rob_multiport.sv
// Directed self-checking bench for rob_multiport: fill/full, multi-port commit, bypass,
// mispredict flush, store retire and reset during a wrapped full buffer.
module tb_rob_multiport;
   import rob_pkg::*;

   localparam int DEPTH    = 16;
   localparam int IDX_W    = 4;
   localparam int NUM_CDB  = 3;
   localparam int COMMIT_W = 2;
   localparam int XLEN     = 32;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   rob_multiport_if #(.IDX_W(IDX_W), .NUM_CDB(NUM_CDB), .COMMIT_W(COMMIT_W), .XLEN(XLEN)) bus ();

   rob_multiport #(
      .DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_CDB(NUM_CDB), .COMMIT_W(COMMIT_W), .XLEN(XLEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cdb_clear();
      bus.cdb_valid  = '0;
      bus.cdb_tag    = '0;
      bus.cdb_data   = '0;
      bus.cdb_taken  = '0;
      bus.cdb_target = '0;
   endtask

   task automatic idle();
      bus.disp_valid   = 1'b0;
      bus.disp_kind    = 2'd0;
      bus.disp_rd      = 5'd0;
      bus.disp_pc      = 32'd0;
      bus.disp_pred_tk = 1'b0;
      bus.rd_tag       = '0;
      cdb_clear();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic dispatch(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
      bus.disp_valid   = 1'b1;
      bus.disp_kind    = kind;
      bus.disp_rd      = rd;
      bus.disp_pc      = pc;
      bus.disp_pred_tk = pred;
      tick();
      bus.disp_valid   = 1'b0;
   endtask

   task automatic cdb_set(input int port, input logic [3:0] tag, input logic [31:0] data,
                          input logic taken, input logic [31:0] target);
      bus.cdb_valid[port]                = 1'b1;
      bus.cdb_tag[port*IDX_W +: IDX_W]   = tag;
      bus.cdb_data[port*XLEN +: XLEN]    = data;
      bus.cdb_taken[port]                = taken;
      bus.cdb_target[port*XLEN +: XLEN]  = target;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
      checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.disp_ready); end
      checks++; if (bus.disp_tag !== 4'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", bus.disp_tag); end
      checks++; if ({bus.cm_we, bus.st_commit, bus.br_valid, bus.br_mispredict} !== 5'b0)
         begin errors++; $display("FAIL reset_outs: got %b want 00000", {bus.cm_we, bus.st_commit, bus.br_valid, bus.br_mispredict}); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (bus.disp_tag !== 4'(i)) begin errors++; $display("FAIL fill_tag%0d: got %0d want %0d", i, bus.disp_tag, i); end
         dispatch(ROB_K_REG, 5'd1, 32'(i * 4), 1'b0);
      end
      checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d want 16", bus.count); end
      checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", bus.disp_ready); end
      dispatch(ROB_K_REG, 5'd2, 32'h200, 1'b0);
      checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_blocked: got %0d want 16", bus.count); end
      checks++; if (bus.cm_we !== 2'b00) begin errors++; $display("FAIL fill_no_commit: got %b want 00", bus.cm_we); end
   endtask

   task automatic test_cdb_commit();
      do_reset();
      dispatch(ROB_K_REG, 5'd5, 32'h00, 1'b0);
      dispatch(ROB_K_REG, 5'd6, 32'h04, 1'b0);
      dispatch(ROB_K_REG, 5'd7, 32'h08, 1'b0);
      cdb_set(0, 4'd0, 32'd10, 1'b0, 32'd0);
      cdb_set(1, 4'd1, 32'd20, 1'b0, 32'd0);
      cdb_set(2, 4'd2, 32'd30, 1'b0, 32'd0);
      tick();
      cdb_clear();
      checks++; if (bus.cm_we !== 2'b00) begin errors++; $display("FAIL cm_early: got %b want 00", bus.cm_we); end
      tick();
      checks++; if (bus.cm_we !== 2'b11) begin errors++; $display("FAIL cm_we_pair: got %b want 11", bus.cm_we); end
      checks++; if (bus.cm_rd !== {5'd6, 5'd5}) begin errors++; $display("FAIL cm_rd_pair: got %h want %h", bus.cm_rd, {5'd6, 5'd5}); end
      checks++; if (bus.cm_data !== {32'd20, 32'd10}) begin errors++; $display("FAIL cm_data_pair: got %h want %h", bus.cm_data, {32'd20, 32'd10}); end
      checks++; if (bus.cm_tag !== {4'd1, 4'd0}) begin errors++; $display("FAIL cm_tag_pair: got %h want 10", bus.cm_tag); end
      tick();
      checks++; if (bus.cm_we !== 2'b01) begin errors++; $display("FAIL cm_we_single: got %b want 01", bus.cm_we); end
      checks++; if (bus.cm_rd !== {5'd0, 5'd7}) begin errors++; $display("FAIL cm_rd_single: got %h want %h", bus.cm_rd, {5'd0, 5'd7}); end
      checks++; if (bus.cm_data[31:0] !== 32'd30) begin errors++; $display("FAIL cm_data_single: got %0d want 30", bus.cm_data[31:0]); end
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL cm_count: got %0d want 0", bus.count); end
   endtask

   task automatic test_bypass();
      dispatch(ROB_K_REG, 5'd9, 32'h30, 1'b0);
      bus.rd_tag = {4'd3, 4'd3};
      #1;
      checks++; if (bus.rd_ready !== 2'b00) begin errors++; $display("FAIL lk_pending: got %b want 00", bus.rd_ready); end
      cdb_set(1, 4'd3, 32'hABCD, 1'b0, 32'd0);
      #1;
      checks++; if (bus.rd_ready !== 2'b11) begin errors++; $display("FAIL lk_bypass_rdy: got %b want 11", bus.rd_ready); end
      checks++; if (bus.rd_data !== {32'hABCD, 32'hABCD}) begin errors++; $display("FAIL lk_bypass_data: got %h want abcd", bus.rd_data); end
      tick();
      cdb_clear();
      bus.rd_tag = {4'd8, 4'd3};
      #1;
      checks++; if (bus.rd_ready !== 2'b01) begin errors++; $display("FAIL lk_stored_rdy: got %b want 01", bus.rd_ready); end
      checks++; if (bus.rd_data !== {32'd0, 32'hABCD}) begin errors++; $display("FAIL lk_stored_data: got %h want 0/abcd", bus.rd_data); end
      tick();
      checks++; if (bus.cm_we !== 2'b01 || bus.cm_data[31:0] !== 32'hABCD || bus.cm_tag[3:0] !== 4'd3)
         begin errors++; $display("FAIL lk_commit: got we=%b data=%h tag=%0d want 01 abcd 3", bus.cm_we, bus.cm_data[31:0], bus.cm_tag[3:0]); end
      bus.rd_tag = '0;
   endtask

   task automatic test_mispredict();
      do_reset();
      dispatch(ROB_K_REG, 5'd1, 32'h00, 1'b0);
      dispatch(ROB_K_BRANCH, 5'd0, 32'h40, 1'b0);
      dispatch(ROB_K_REG, 5'd2, 32'h48, 1'b0);
      cdb_set(0, 4'd0, 32'h11, 1'b0, 32'd0);
      cdb_set(1, 4'd2, 32'h22, 1'b0, 32'd0);
      cdb_set(2, 4'd1, 32'h0, 1'b1, 32'h100);
      tick();
      cdb_clear();
      tick();
      checks++; if (bus.cm_we !== 2'b01 || bus.cm_data[31:0] !== 32'h11)
         begin errors++; $display("FAIL mp_first: got we=%b data=%h want 01 11", bus.cm_we, bus.cm_data[31:0]); end
      checks++; if (bus.br_valid !== 1'b0) begin errors++; $display("FAIL mp_br_early: got %b want 0", bus.br_valid); end
      bus.disp_valid = 1'b1;
      bus.disp_kind  = ROB_K_REG;
      bus.disp_rd    = 5'd3;
      tick();
      bus.disp_valid = 1'b0;
      checks++; if (bus.br_valid !== 1'b1 || bus.br_mispredict !== 1'b1)
         begin errors++; $display("FAIL mp_flag: got valid=%b mis=%b want 1 1", bus.br_valid, bus.br_mispredict); end
      checks++; if (bus.br_target !== 32'h100 || bus.br_pc !== 32'h40 || bus.br_taken !== 1'b1)
         begin errors++; $display("FAIL mp_info: got tgt=%h pc=%h tk=%b want 100 40 1", bus.br_target, bus.br_pc, bus.br_taken); end
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL mp_count: got %0d want 0", bus.count); end
      checks++; if (bus.disp_tag !== 4'd2) begin errors++; $display("FAIL mp_tail: got %0d want 2", bus.disp_tag); end
      checks++; if (bus.cm_we !== 2'b00) begin errors++; $display("FAIL mp_cm: got %b want 00", bus.cm_we); end
      tick();
      checks++; if (bus.br_mispredict !== 1'b0) begin errors++; $display("FAIL mp_pulse: got %b want 0", bus.br_mispredict); end
      checks++; if (bus.cm_we !== 2'b00 || bus.count !== 5'd0)
         begin errors++; $display("FAIL mp_squash: got we=%b count=%0d want 00 0", bus.cm_we, bus.count); end
   endtask

   task automatic test_store();
      dispatch(ROB_K_STORE, 5'd0, 32'h80, 1'b0);
      dispatch(ROB_K_REG, 5'd4, 32'h84, 1'b0);
      cdb_set(1, 4'd2, 32'h5, 1'b0, 32'd0);
      cdb_set(0, 4'd3, 32'h44, 1'b0, 32'd0);
      tick();
      cdb_clear();
      tick();
      checks++; if (bus.st_commit !== 1'b1 || bus.st_tag !== 4'd2)
         begin errors++; $display("FAIL st_commit: got %b tag=%0d want 1 2", bus.st_commit, bus.st_tag); end
      checks++; if (bus.cm_we !== 2'b00) begin errors++; $display("FAIL st_cm_we: got %b want 00", bus.cm_we); end
      checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL st_count: got %0d want 1", bus.count); end
      tick();
      checks++; if (bus.st_commit !== 1'b0) begin errors++; $display("FAIL st_pulse: got %b want 0", bus.st_commit); end
      checks++; if (bus.cm_we !== 2'b01 || bus.cm_rd !== {5'd0, 5'd4} || bus.cm_data[31:0] !== 32'h44)
         begin errors++; $display("FAIL st_follow: got we=%b rd=%h data=%h want 01 004 44", bus.cm_we, bus.cm_rd, bus.cm_data[31:0]); end
   endtask

   task automatic test_wrap_reset();
      do_reset();
      for (int i = 0; i < 12; i++) dispatch(ROB_K_REG, 5'd1, 32'(i * 4), 1'b0);
      for (int j = 0; j < 4; j++) begin
         for (int p = 0; p < 3; p++) cdb_set(p, 4'(3 * j + p), 32'(3 * j + p), 1'b0, 32'd0);
         tick();
         cdb_clear();
      end
      for (int j = 0; j < 8; j++) tick();
      checks++; if (bus.count !== 5'd0 || bus.disp_tag !== 4'd12)
         begin errors++; $display("FAIL wr_drain: got count=%0d tag=%0d want 0 12", bus.count, bus.disp_tag); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (bus.disp_tag !== 4'((12 + i) % 16))
            begin errors++; $display("FAIL wr_tag%0d: got %0d want %0d", i, bus.disp_tag, (12 + i) % 16); end
         dispatch(ROB_K_REG, 5'd2, 32'h300, 1'b0);
      end
      checks++; if (bus.count !== 5'd16 || bus.disp_ready !== 1'b0)
         begin errors++; $display("FAIL wr_full: got count=%0d ready=%b want 16 0", bus.count, bus.disp_ready); end
      cdb_set(0, 4'd12, 32'h77, 1'b0, 32'd0);
      cdb_set(1, 4'd13, 32'h88, 1'b0, 32'd0);
      tick();
      cdb_clear();
      rst = 1'b0;
      bus.disp_valid = 1'b1;
      cdb_set(2, 4'd14, 32'h99, 1'b0, 32'd0);
      tick();
      checks++; if (bus.cm_we !== 2'b00 || bus.cm_data !== 64'd0)
         begin errors++; $display("FAIL wr_rst_cm: got we=%b data=%h want 00 0", bus.cm_we, bus.cm_data); end
      checks++; if ({bus.st_commit, bus.br_valid, bus.br_mispredict} !== 3'b000)
         begin errors++; $display("FAIL wr_rst_side: got %b want 000", {bus.st_commit, bus.br_valid, bus.br_mispredict}); end
      checks++; if (bus.count !== 5'd0 || bus.disp_ready !== 1'b1 || bus.disp_tag !== 4'd0)
         begin errors++; $display("FAIL wr_rst_ptr: got count=%0d ready=%b tag=%0d want 0 1 0", bus.count, bus.disp_ready, bus.disp_tag); end
      rst = 1'b1;
      idle();
      bus.rd_tag = {4'd14, 4'd12};
      #1;
      checks++; if (bus.rd_ready !== 2'b00 || bus.rd_data !== 64'd0)
         begin errors++; $display("FAIL wr_rst_lookup: got rdy=%b data=%h want 00 0", bus.rd_ready, bus.rd_data); end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      test_reset();
      test_fill();
      test_cdb_commit();
      test_bypass();
      test_mispredict();
      test_store();
      test_wrap_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
